// File: rtl/dna_pkg.sv
// Shared DNA symbol encodings, orientation prefixes and transmit FSM states.
// The decoder uses the same prefix constants.
package dna_pkg;

    typedef logic [1:0] sym_t;

    localparam sym_t SYM_1 = 2'b01;
    localparam sym_t SYM_2 = 2'b10;
    localparam sym_t SYM_3 = 2'b11;
    localparam sym_t SYM_4 = 2'b00;

    // Upper symbol goes out first.
    localparam logic [3:0] PFX_FWD = 4'b0100;
    localparam logic [3:0] PFX_REV = 4'b1011;

    typedef enum logic [1:0] {IDLE, PRE0, PRE1, PAY} tx_state_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n - 2 > 1) ? $clog2(n - 2) : 1;
    endfunction

endpackage

// File: rtl/prefix_tx_if.sv
// Payload-in and symbol-out streams of prefix_tx; slave is the transmitter's view.
interface prefix_tx_if
    import dna_pkg::*;
#(
    parameter int unsigned N = 100
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*(N-2)-1:0]   payload_in;
    logic                 reverse_in;
    logic                 sym_valid;
    logic                 sym_ready;
    sym_t                 sym_out;
    logic                 sym_first;
    logic                 sym_last;
    logic                 busy;

    modport master (
        output in_valid, payload_in, reverse_in, sym_ready,
        input  in_ready, sym_valid, sym_out, sym_first, sym_last, busy
    );

    modport slave (
        input  in_valid, payload_in, reverse_in, sym_ready,
        output in_ready, sym_valid, sym_out, sym_first, sym_last, busy
    );

endinterface

// File: rtl/prefix_tx.sv
// Frames an (N-2)-symbol payload with a 2-symbol orientation prefix and
// serializes it one symbol per handshake over a valid/ready stream.
module prefix_tx
    import dna_pkg::*;
#(
    parameter int unsigned N = 100
) (
    input  logic         clk,
    input  logic         rst,
    prefix_tx_if.slave   tx
);

    localparam int unsigned     PW       = 2 * (N - 2);
    localparam int unsigned     CW       = cnt_w(N);
    localparam logic [CW-1:0]   CNT_INIT = CW'(N - 3);

    tx_state_t       r_state, w_state_nxt;
    logic [PW-1:0]   r_shift, w_shift_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_rev, w_rev_nxt;
    logic            r_sym_valid, r_sym_first, r_sym_last;
    sym_t            r_sym_out, w_sym_nxt;
    logic            w_in_hs, w_sym_hs;

    assign w_in_hs  = tx.in_valid && (r_state == IDLE);
    assign w_sym_hs = r_sym_valid && tx.sym_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_rev       <= 1'b0;
            r_sym_valid <= 1'b0;
            r_sym_out   <= SYM_4;
            r_sym_first <= 1'b0;
            r_sym_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rev       <= w_rev_nxt;
            r_sym_valid <= (w_state_nxt != IDLE);
            r_sym_out   <= w_sym_nxt;
            r_sym_first <= (w_state_nxt == PRE0);
            r_sym_last  <= (w_state_nxt == PAY) && (w_cnt_nxt == '0);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_rev_nxt   = r_rev;
        w_sym_nxt   = SYM_4;

        case (r_state)
            IDLE: if (w_in_hs) begin
                w_state_nxt = PRE0;
                w_shift_nxt = tx.payload_in;
                w_cnt_nxt   = CNT_INIT;
                w_rev_nxt   = tx.reverse_in;
            end
            PRE0: if (w_sym_hs) w_state_nxt = PRE1;
            PRE1: if (w_sym_hs) w_state_nxt = PAY;
            PAY: if (w_sym_hs) begin
                w_shift_nxt = r_rev ? (r_shift >> 2) : (r_shift << 2);
                if (r_cnt == '0) w_state_nxt = IDLE;
                else             w_cnt_nxt   = r_cnt - CW'(1);
            end
            default: w_state_nxt = IDLE;
        endcase

        // Outputs are registered, so the symbol is chosen from next-state values.
        case (w_state_nxt)
            PRE0:    w_sym_nxt = w_rev_nxt ? PFX_REV[3:2] : PFX_FWD[3:2];
            PRE1:    w_sym_nxt = w_rev_nxt ? PFX_REV[1:0] : PFX_FWD[1:0];
            PAY:     w_sym_nxt = w_rev_nxt ? w_shift_nxt[1:0] : w_shift_nxt[PW-1 -: 2];
            default: w_sym_nxt = SYM_4;
        endcase
    end

    assign tx.in_ready  = (r_state == IDLE);
    assign tx.busy      = (r_state != IDLE);
    assign tx.sym_valid = r_sym_valid;
    assign tx.sym_out   = r_sym_out;
    assign tx.sym_first = r_sym_first;
    assign tx.sym_last  = r_sym_last;

endmodule
